// File: rtl/ic_mem_resp_pkg.sv
// Shared types and sizes for the icache-to-DRAM line-fill path.
package ic_mem_resp_pkg;
    localparam int IC_ADDR_W     = 23;
    localparam int IC_XID_W      = 2;
    localparam int IC_FILL_BEATS = 8;
    localparam int IC_BEAT_W     = 16;
    localparam int IC_LINE_W     = IC_FILL_BEATS * IC_BEAT_W;

    // addr holds line address bits [26:4]
    typedef struct packed {
        logic [IC_ADDR_W-1:0] addr;
        logic [IC_XID_W-1:0]  xid;
    } ic_mem_req_t;

    typedef enum logic [1:0] {FILL_IDLE, FILL_REQ, FILL_DATA, FILL_RESP} ic_fill_state_e;
endpackage

// File: rtl/ic_mem_req_fifo.sv
// Circular request queue between the icache and the fill engine.
module ic_mem_req_fifo
    import ic_mem_resp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  ic_mem_req_t              din,
    output ic_mem_req_t              dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_V = (AW+1)'(DEPTH);

    ic_mem_req_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == DEPTH_V);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // Power-of-two depth lets the pointers wrap on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/ic_mem_resp.sv
// Queues icache line-fill requests, runs each as a DRAM burst read and
// returns the assembled line tagged with its xid.
module ic_mem_resp
    import ic_mem_resp_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int BEATS  = IC_FILL_BEATS,
    parameter int BEAT_W = IC_BEAT_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [IC_ADDR_W-1:0]      ic_mem_addr,
    input  logic [IC_XID_W-1:0]       ic_mem_xid,
    input  logic                      ic_mem_re,
    output logic                      mem_ic_ready,
    output logic                      mem_ic_valid,
    output logic [IC_XID_W-1:0]       mem_ic_xid,
    output logic [BEATS*BEAT_W-1:0]   mem_ic_data,
    output logic                      dram_rd_req,
    output logic [IC_ADDR_W-1:0]      dram_rd_addr,
    input  logic                      dram_rd_gnt,
    input  logic                      dram_rd_valid,
    input  logic [BEAT_W-1:0]         dram_rd_data
);
    localparam int              AW        = $clog2(DEPTH);
    localparam int              BW        = $clog2(BEATS);
    localparam logic [BW-1:0]   LAST_BEAT = BW'(BEATS - 1);
    localparam logic [AW+1:0]   DEPTH_V   = (AW+2)'(DEPTH);

    logic                     ready_q;
    logic                     accept;
    logic                     fifo_pop;
    logic                     fifo_empty;
    logic                     fifo_full;
    logic [AW:0]              fifo_count;
    logic [AW+1:0]            occupancy;
    ic_mem_req_t              fifo_din;
    ic_mem_req_t              fifo_dout;
    ic_fill_state_e           state;
    logic [BW-1:0]            beat;
    logic [IC_XID_W-1:0]      work_xid;
    logic [BEATS*BEAT_W-1:0]  line;

    assign accept    = ic_mem_re & ready_q;
    assign fifo_din  = '{addr: ic_mem_addr, xid: ic_mem_xid};
    assign fifo_pop  = (state == FILL_IDLE) & ~fifo_empty;

    // Credit looks one cycle ahead: counting this cycle's accept keeps a slot
    // free for whatever arrives while ready_q still shows the old value.
    assign occupancy    = {1'b0, fifo_count} + {{(AW+1){1'b0}}, accept};
    assign mem_ic_ready = rst_n & ~fifo_full & (occupancy < DEPTH_V);
    assign mem_ic_data  = line;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_q <= 1'b0;
        else        ready_q <= mem_ic_ready;
    end

    ic_mem_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= FILL_IDLE;
            beat         <= '0;
            line         <= '0;
            work_xid     <= '0;
            dram_rd_req  <= 1'b0;
            dram_rd_addr <= '0;
            mem_ic_valid <= 1'b0;
            mem_ic_xid   <= '0;
        end else begin
            case (state)
                FILL_IDLE: begin
                    if (!fifo_empty) begin
                        dram_rd_addr <= fifo_dout.addr;
                        work_xid     <= fifo_dout.xid;
                        dram_rd_req  <= 1'b1;
                        state        <= FILL_REQ;
                    end
                end
                FILL_REQ: begin
                    if (dram_rd_gnt) begin
                        dram_rd_req <= 1'b0;
                        beat        <= '0;
                        state       <= FILL_DATA;
                    end
                end
                FILL_DATA: begin
                    // Beats are only taken here, so stray valids elsewhere are harmless.
                    if (dram_rd_valid) begin
                        line[beat*BEAT_W +: BEAT_W] <= dram_rd_data;
                        beat <= beat + 1'b1;
                        if (beat == LAST_BEAT) begin
                            mem_ic_valid <= 1'b1;
                            mem_ic_xid   <= work_xid;
                            state        <= FILL_RESP;
                        end
                    end
                end
                FILL_RESP: begin
                    mem_ic_valid <= 1'b0;
                    state        <= FILL_IDLE;
                end
                default: state <= FILL_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ic_mem_resp.sv
// Directed bench for ic_mem_resp: fills, credit, reset, ordering, beat gaps.
module tb_ic_mem_resp;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [22:0]   ic_mem_addr = '0;
    logic [1:0]    ic_mem_xid = '0;
    logic          ic_mem_re = 1'b0;
    logic          mem_ic_ready;
    logic          mem_ic_valid;
    logic [1:0]    mem_ic_xid;
    logic [127:0]  mem_ic_data;
    logic          dram_rd_req;
    logic [22:0]   dram_rd_addr;
    logic          dram_rd_gnt = 1'b0;
    logic          dram_rd_valid = 1'b0;
    logic [15:0]   dram_rd_data = '0;

    int tests = 0;
    int fails = 0;
    bit ovf;

    always #5 clk = ~clk;

    ic_mem_resp #(.DEPTH(4), .BEATS(8), .BEAT_W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ic_mem_addr   (ic_mem_addr),
        .ic_mem_xid    (ic_mem_xid),
        .ic_mem_re     (ic_mem_re),
        .mem_ic_ready  (mem_ic_ready),
        .mem_ic_valid  (mem_ic_valid),
        .mem_ic_xid    (mem_ic_xid),
        .mem_ic_data   (mem_ic_data),
        .dram_rd_req   (dram_rd_req),
        .dram_rd_addr  (dram_rd_addr),
        .dram_rd_gnt   (dram_rd_gnt),
        .dram_rd_valid (dram_rd_valid),
        .dram_rd_data  (dram_rd_data)
    );

    // An accepted request must never land on a full queue.
    always @(posedge clk) begin
        if (rst_n && ic_mem_re && dut.ready_q && dut.fifo_full) ovf <= 1'b1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, tests=%0d fails=%0d", tests, fails);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nclk();
        @(negedge clk);
    endtask

    function automatic logic [127:0] line_of(input logic [15:0] base);
        logic [127:0] l;
        for (int k = 0; k < 8; k++) l[16*k +: 16] = base + 16'(k);
        return l;
    endfunction

    task automatic req(input logic [22:0] a, input logic [1:0] x);
        ic_mem_re = 1'b1; ic_mem_addr = a; ic_mem_xid = x;
        nclk();
        ic_mem_re = 1'b0;
    endtask

    task automatic beats(input logic [15:0] base, input int gap);
        for (int k = 0; k < 8; k++) begin
            dram_rd_valid = 1'b1; dram_rd_data = base + 16'(k);
            nclk();
            if (k < 7 && gap > 0) begin
                dram_rd_valid = 1'b0; dram_rd_data = 16'hdead;
                for (int g = 0; g < gap; g++) nclk();
                if (k == 6) chk("no_early_valid", mem_ic_valid, 0);
            end
        end
        dram_rd_valid = 1'b0; dram_rd_data = '0;
    endtask

    task automatic fill(input logic [22:0] a, input logic [1:0] x, input logic [15:0] base,
                        input int gap, input bit spur);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (dram_rd_req === 1'b1) begin seen = 1'b1; break; end
            nclk();
        end
        chk("req_seen", seen, 1);
        chk("req_addr", dram_rd_addr, a);
        if (spur) begin dram_rd_valid = 1'b1; dram_rd_data = 16'hbad0; end
        nclk();
        dram_rd_valid = 1'b0; dram_rd_data = '0;
        chk("req_held", dram_rd_req, 1);
        dram_rd_gnt = 1'b1;
        nclk();
        dram_rd_gnt = 1'b0;
        chk("req_drop", dram_rd_req, 0);
        beats(base, gap);
        chk("resp_valid", mem_ic_valid, 1);
        chk("resp_xid", mem_ic_xid, x);
        chk("resp_data", mem_ic_data, line_of(base));
        nclk();
        chk("resp_pulse", mem_ic_valid, 0);
    endtask

    initial begin
        // Reset state
        nclk();
        chk("rst_ready", mem_ic_ready, 0);
        chk("rst_valid", mem_ic_valid, 0);
        chk("rst_xid", mem_ic_xid, 0);
        chk("rst_data", mem_ic_data, 0);
        chk("rst_req", dram_rd_req, 0);
        chk("rst_addr", dram_rd_addr, 0);
        nclk();
        rst_n = 1'b1;
        nclk();

        // 1: single fill, latency accept -> req is two cycles
        chk("ready_after_reset", mem_ic_ready, 1);
        req(23'h012345, 2'd2);
        chk("lat_cycle1", dram_rd_req, 0);
        nclk();
        chk("lat_cycle2", dram_rd_req, 1);
        fill(23'h012345, 2'd2, 16'h1000, 0, 1'b0);
        chk("t1_line", mem_ic_data, 128'h1007_1006_1005_1004_1003_1002_1001_1000);

        // 2: credit with grant held low; 1 working + 4 queued, 6th dropped
        ic_mem_re = 1'b1;
        ic_mem_addr = 23'h000100; ic_mem_xid = 2'd0; nclk();
        ic_mem_addr = 23'h000200; ic_mem_xid = 2'd1; nclk();
        ic_mem_addr = 23'h000300; ic_mem_xid = 2'd2; nclk();
        ic_mem_addr = 23'h000400; ic_mem_xid = 2'd3; nclk();
        ic_mem_addr = 23'h000500; ic_mem_xid = 2'd0; nclk();
        chk("credit_ready_low", mem_ic_ready, 0);
        ic_mem_addr = 23'h000600; ic_mem_xid = 2'd1; nclk();
        chk("credit_ready_low2", mem_ic_ready, 0);
        ic_mem_re = 1'b0;
        fill(23'h000100, 2'd0, 16'h2000, 0, 1'b0);
        fill(23'h000200, 2'd1, 16'h2100, 0, 1'b0);
        fill(23'h000300, 2'd2, 16'h2200, 0, 1'b0);
        fill(23'h000400, 2'd3, 16'h2300, 0, 1'b0);
        fill(23'h000500, 2'd0, 16'h2400, 0, 1'b0);
        repeat (4) nclk();
        chk("dropped_6th", dram_rd_req, 0);
        chk("ready_restored", mem_ic_ready, 1);

        // 4: gapped beats with a spurious valid during REQ
        req(23'h7abcde, 2'd1);
        fill(23'h7abcde, 2'd1, 16'h4000, 1, 1'b1);

        // 5: push+pop at count 1, then pointer wrap
        ic_mem_re = 1'b1;
        ic_mem_addr = 23'h000a01; ic_mem_xid = 2'd3; nclk();
        ic_mem_addr = 23'h000a02; ic_mem_xid = 2'd0; nclk();
        chk("push_pop_count", dut.fifo_count, 1);
        ic_mem_addr = 23'h000a03; ic_mem_xid = 2'd1; nclk();
        ic_mem_re = 1'b0;
        fill(23'h000a01, 2'd3, 16'h5000, 0, 1'b0);
        fill(23'h000a02, 2'd0, 16'h5100, 0, 1'b0);
        fill(23'h000a03, 2'd1, 16'h5200, 0, 1'b0);

        // 3: reset drops a pending req, then re while ready_q=0 is ignored
        req(23'h055555, 2'd2);
        nclk();
        chk("pend_req", dram_rd_req, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_req_async", dram_rd_req, 0);
        chk("rst_addr_async", dram_rd_addr, 0);
        chk("rst_ready_async", mem_ic_ready, 0);
        nclk(); nclk();
        rst_n = 1'b1;
        ic_mem_re = 1'b1; ic_mem_addr = 23'h0600aa; ic_mem_xid = 2'd3;
        nclk();
        nclk();
        ic_mem_re = 1'b0;
        chk("ignore_not_ready", dram_rd_req, 0);
        nclk();
        chk("represent_req", dram_rd_req, 1);
        fill(23'h0600aa, 2'd3, 16'h6000, 0, 1'b0);
        repeat (4) nclk();
        chk("accepted_once", dram_rd_req, 0);

        // 6: reset in DATA at beat 3
        req(23'h0123ab, 2'd0);
        nclk();
        chk("t6_req", dram_rd_req, 1);
        dram_rd_gnt = 1'b1; nclk(); dram_rd_gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            dram_rd_valid = 1'b1; dram_rd_data = 16'h7000 + 16'(k);
            nclk();
        end
        dram_rd_data = 16'h7003;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", mem_ic_valid, 0);
        chk("mid_rst_xid", mem_ic_xid, 0);
        chk("mid_rst_data", mem_ic_data, 0);
        chk("mid_rst_req", dram_rd_req, 0);
        chk("mid_rst_ready", mem_ic_ready, 0);
        dram_rd_valid = 1'b0; dram_rd_data = '0;
        nclk(); nclk();
        rst_n = 1'b1;
        nclk();
        req(23'h0456cd, 2'd1);
        fill(23'h0456cd, 2'd1, 16'h8000, 0, 1'b0);

        chk("no_overflow", ovf, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
